// File: rtl/alu_sched_pkg.sv
// Shared opcodes, FSM state encoding and the captured-flag layout for the ALU scheduler.
// Also holds the helper that qualifies raw ALU flags by opcode.
package alu_sched_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SL  = 3'b010;
    localparam logic [2:0] OP_SR  = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_POW = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic sign;
        logic zero;
        logic parity;
        logic ovf;
    } flags_t;

    // Sign is only meaningful for arithmetic, overflow only for ADD; the ALU may
    // drive garbage on those flags otherwise, so force them to a known 0.
    function automatic flags_t mask_flags(input logic [2:0] op,
                                          input logic       sign,
                                          input logic       zero,
                                          input logic       parity,
                                          input logic       ovf);
        flags_t f;
        f.sign   = 1'b0;
        f.ovf    = 1'b0;
        if (op == OP_ADD || op == OP_SUB) begin
            f.sign = sign;
        end
        if (op == OP_ADD) begin
            f.ovf = ovf;
        end
        f.zero   = zero;
        f.parity = parity;
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req from ptr upwards (wrapping)
// and returns a one-hot grant plus the granted index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!any_o && req_i[cand[IW-1:0]]) begin
                any_o                  = 1'b1;
                grant_o[cand[IW-1:0]]  = 1'b1;
                idx_o                  = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Time-shares one combinational flag-producing ALU between NREQ requesters:
// grant (IDLE) -> drive ALU (ISSUE) -> hold response until accepted (RESP).
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [3*NREQ-1:0]        req_op_i,
    input  logic [DW*NREQ-1:0]       req_a_i,
    input  logic [DW*NREQ-1:0]       req_b_i,
    output logic [2:0]               alu_op_o,
    output logic [DW-1:0]            alu_a_o,
    output logic [DW-1:0]            alu_b_o,
    input  logic [DW-1:0]            alu_out_i,
    input  logic                     alu_sign_i,
    input  logic                     alu_zero_i,
    input  logic                     alu_parity_i,
    input  logic                     alu_ovf_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [$clog2(NREQ)-1:0]  rsp_id_o,
    output logic [DW-1:0]            rsp_data_o,
    output logic [3:0]               rsp_flags_o
);

    localparam int IW = $clog2(NREQ);

    logic [2:0]    op_arr [NREQ];
    logic [DW-1:0] a_arr  [NREQ];
    logic [DW-1:0] b_arr  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi] = req_op_i[3*gi +: 3];
        assign a_arr[gi]  = req_a_i[DW*gi +: DW];
        assign b_arr[gi]  = req_b_i[DW*gi +: DW];
    end

    state_t        state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] idx_q;
    logic [2:0]    op_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    flags_t        rsp_flags_q;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign ptr_d = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

    // The grant is visible in the same cycle it is decided; reset masks it so
    // no requester sees an accept while the block is held in reset.
    assign req_ready_o = (rst_n && state_q == S_IDLE) ? arb_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_any) begin
                        op_q    <= op_arr[arb_idx];
                        a_q     <= a_arr[arb_idx];
                        b_q     <= b_arr[arb_idx];
                        idx_q   <= arb_idx;
                        ptr_q   <= ptr_d;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rsp_data_q  <= alu_out_i;
                    rsp_flags_q <= mask_flags(op_q, alu_sign_i, alu_zero_i,
                                              alu_parity_i, alu_ovf_i);
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Operand registers only load on a grant, so the ALU inputs stay quiet
    // outside the single ISSUE cycle.
    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = idx_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_flags_o = rsp_flags_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: the bench plays the shared ALU and keeps a
// transaction-level model of grants and responses checked every cycle.
module tb_alu_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic [2:0]        alu_op;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [DW-1:0]     alu_out;
    logic              alu_sign;
    logic              alu_zero;
    logic              alu_parity;
    logic              alu_ovf;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic [3:0]        rsp_flags;

    alu_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .alu_op_o     (alu_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_out_i    (alu_out),
        .alu_sign_i   (alu_sign),
        .alu_zero_i   (alu_zero),
        .alu_parity_i (alu_parity),
        .alu_ovf_i    (alu_ovf),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .rsp_flags_o  (rsp_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0] p;
        p = 16'd1;
        case (op)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a << b[3:0];
            3'b011: return a >> b[3:0];
            3'b100: return a | b;
            3'b101: return a & b;
            3'b110: return a ^ b;
            default: begin
                for (int i = 0; i < 16; i++) if (i < int'(b[3:0])) p = p * a;
                return p;
            end
        endcase
    endfunction

    // Shared ALU: sign/overflow are junk (1) where they carry no meaning.
    logic [15:0] alu_res;
    always_comb begin
        alu_res    = alu_calc(alu_op, alu_a, alu_b);
        alu_out    = alu_res;
        alu_zero   = (alu_res == 16'h0000);
        alu_parity = ~^alu_res;
        alu_sign   = 1'b1;
        alu_ovf    = 1'b1;
        if (alu_op == 3'b000 || alu_op == 3'b001) alu_sign = alu_res[15];
        if (alu_op == 3'b000) alu_ovf = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
        if (alu_op == 3'b001) alu_ovf = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
    end

    // Expected captured flags {sign, zero, parity, ovf} from the operation itself.
    function automatic logic [3:0] exp_flags(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0] r;
        logic s, o;
        r = alu_calc(op, a, b);
        s = (op == 3'b000 || op == 3'b001) ? r[15] : 1'b0;
        o = (op == 3'b000) ? ((a[15] == b[15]) && (r[15] != a[15])) : 1'b0;
        return {s, (r == 16'h0000), ~^r, o};
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: phase 0 waiting for a grant, 1 operation in flight, 2 response offered.
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    logic [2:0]  m_op    = '0;
    logic [15:0] m_a     = '0;
    logic [15:0] m_b     = '0;
    logic [15:0] m_data  = '0;
    logic [3:0]  m_flags = '0;
    logic        prev_rv = 1'b0;

    int          g_cyc[$];
    int          g_id[$];
    int          r_cyc[$];
    int          r_id[$];
    logic [15:0] r_data[$];
    logic [3:0]  r_flags[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_cycle();
        logic [3:0] exp_ready;
        int gidx;
        int dut_g;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
            chk("rst_rsp_flags", 32'(rsp_flags), 0);
            chk("rst_alu_op", 32'(alu_op), 0);
            chk("rst_alu_a", 32'(alu_a), 0);
            chk("rst_alu_b", 32'(alu_b), 0);
            m_phase = 0; m_ptr = 0; m_id = 0; m_op = '0; m_a = '0; m_b = '0;
            prev_rv = 1'b0;
            cyc++;
            return;
        end
        exp_ready = '0;
        gidx = -1;
        if (m_phase == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (gidx < 0 && req_valid[i]) begin
                    gidx = i;
                    exp_ready[i] = 1'b1;
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("alu_op", 32'(alu_op), 32'(m_op));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        if (m_phase == 2) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
            chk("rsp_flags", 32'(rsp_flags), 32'(m_flags));
        end
        if (req_ready != '0) begin
            dut_g = -1;
            for (int k = NREQ - 1; k >= 0; k--) if (req_ready[k]) dut_g = k;
            g_cyc.push_back(cyc);
            g_id.push_back(dut_g);
            $display("grant    cyc=%0d id=%0d", cyc, dut_g);
        end
        if (rsp_valid && !prev_rv) begin
            r_cyc.push_back(cyc);
            r_id.push_back(int'(rsp_id));
            r_data.push_back(rsp_data);
            r_flags.push_back(rsp_flags);
            $display("response cyc=%0d id=%0d data=%h flags=%b", cyc, rsp_id, rsp_data, rsp_flags);
        end
        prev_rv = rsp_valid;
        case (m_phase)
            0: if (gidx >= 0) begin
                m_op  = req_op[3*gidx +: 3];
                m_a   = req_a[16*gidx +: 16];
                m_b   = req_b[16*gidx +: 16];
                m_id  = gidx;
                m_ptr = (gidx + 1) % NREQ;
                m_phase = 1;
            end
            1: begin
                m_data  = alu_calc(m_op, m_a, m_b);
                m_flags = exp_flags(m_op, m_a, m_b);
                m_phase = 2;
            end
            default: if (rsp_ready) m_phase = 0;
        endcase
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b);
        req_valid[idx]      = 1'b1;
        req_op[3*idx +: 3]  = op;
        req_a[16*idx +: 16] = a;
        req_b[16*idx +: 16] = b;
    endtask

    task automatic wait_grant(input int n0, input string name);
        int t;
        t = 0;
        while (g_id.size() <= n0 && t < 40) begin
            step();
            t++;
        end
        chk(name, 32'(g_id.size() > n0), 1);
    endtask

    task automatic issue_one(input int idx, input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input string name);
        int n0;
        n0 = g_id.size();
        set_req(idx, op, a, b);
        wait_grant(n0, name);
        req_valid[idx] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int n0;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // ADD overflow into the sign bit, two-cycle latency
        issue_one(0, 3'b000, 16'h7FFF, 16'h0001, "add_grant");
        step(); step(); step();
        chk("add_latency", 32'(r_cyc[$] - g_cyc[$]), 2);
        chk("add_id", 32'(r_id[$]), 0);
        chk("add_data", 32'(r_data[$]), 32'h8000);
        chk("add_flags", 32'(r_flags[$]), 32'b1001);

        // All four requesting continuously: fair order, 3-cycle spacing
        do_reset();
        set_req(0, 3'b000, 16'h0001, 16'h0002);
        set_req(1, 3'b010, 16'h0001, 16'h0004);
        set_req(2, 3'b101, 16'hF0F0, 16'h3C3C);
        set_req(3, 3'b111, 16'h0003, 16'h0003);
        n0 = g_id.size();
        for (int t = 0; t < 40 && g_id.size() < n0 + 5; t++) step();
        chk("rr_five_grants", 32'(g_id.size() >= n0 + 5), 1);
        req_valid = '0;
        step(); step(); step(); step();
        chk("rr_order0", 32'(g_id[n0]), 0);
        chk("rr_order1", 32'(g_id[n0+1]), 1);
        chk("rr_order2", 32'(g_id[n0+2]), 2);
        chk("rr_order3", 32'(g_id[n0+3]), 3);
        chk("rr_order4", 32'(g_id[n0+4]), 0);
        for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(g_cyc[n0+k] - g_cyc[n0+k-1]), 3);
        chk("pow_data", 32'(r_data[$-1]), 27);

        // XOR to zero: sign/ovf masked even though the ALU drives them high
        issue_one(2, 3'b110, 16'h00FF, 16'h00FF, "xor_grant");
        step(); step(); step();
        chk("xor_id", 32'(r_id[$]), 2);
        chk("xor_data", 32'(r_data[$]), 0);
        chk("xor_flags", 32'(r_flags[$]), 32'b0110);

        // SUB with a 5-cycle consumer stall while another requester waits
        rsp_ready = 1'b0;
        issue_one(1, 3'b001, 16'h0003, 16'h0005, "sub_grant");
        set_req(0, 3'b101, 16'hF0F0, 16'h3C3C);
        step(); step();
        n0 = g_id.size();
        repeat (5) step();
        chk("stall_no_grant", 32'(g_id.size()), 32'(n0));
        chk("stall_valid", 32'(rsp_valid), 1);
        chk("sub_data", 32'(r_data[$]), 32'hFFFE);
        chk("sub_flags", 32'(r_flags[$]), 32'b1000);
        rsp_ready = 1'b1;
        wait_grant(n0, "post_stall_grant");
        req_valid[0] = 1'b0;
        chk("post_stall_id", 32'(g_id[$]), 0);
        step(); step(); step();

        // Reset while a response is pending discards it and rewinds ptr
        rsp_ready = 1'b0;
        issue_one(2, 3'b100, 16'h1234, 16'h00F0, "or_grant");
        step(); step();
        chk("pre_rst_valid", 32'(rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 0);
        chk("async_rsp_data", 32'(rsp_data), 0);
        set_req(3, 3'b011, 16'h8000, 16'h000F);
        set_req(1, 3'b000, 16'h0010, 16'h0020);
        step(); step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        n0 = g_id.size();
        wait_grant(n0, "after_rst_grant");
        req_valid[1] = 1'b0;
        chk("after_rst_id", 32'(g_id[$]), 1);
        n0 = g_id.size();
        wait_grant(n0, "after_rst_grant3");
        req_valid[3] = 1'b0;
        step(); step(); step();
        chk("sr_data", 32'(r_data[$]), 1);

        // Requester 3 alone after its own grant; ptr wrapped to 0
        issue_one(3, 3'b111, 16'h0002, 16'h0005, "solo3_a");
        step(); step(); step();
        chk("solo3_a_id", 32'(g_id[$]), 3);
        chk("solo3_a_data", 32'(r_data[$]), 32);
        issue_one(3, 3'b000, 16'h8000, 16'h8000, "solo3_b");
        step(); step(); step();
        chk("solo3_b_id", 32'(g_id[$]), 3);
        chk("solo3_b_flags", 32'(r_flags[$]), 32'b0111);
        set_req(0, 3'b110, 16'hAAAA, 16'h5555);
        set_req(3, 3'b010, 16'h0001, 16'h000F);
        n0 = g_id.size();
        wait_grant(n0, "wrap_grant");
        req_valid[0] = 1'b0;
        chk("wrap_id", 32'(g_id[$]), 0);
        n0 = g_id.size();
        wait_grant(n0, "wrap_grant3");
        req_valid[3] = 1'b0;
        chk("wrap_id3", 32'(g_id[$]), 3);
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one 16-bit flag-producing ALU; the block SHALL support 2..8.
REQ-002 Parameter DW, default 16, operand/result width; the block SHALL be verified at 16 only.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_op  input  3*NREQ  opcode, slice i = requester i: 000 ADD, 001 SUB, 010 SL, 011 SR, 100 OR, 101 AND, 110 XOR, 111 POW.
REQ-008 req_a, req_b  input  DW*NREQ  operands, slice i = requester i.
REQ-009 alu_op  output  3  opcode driven to the shared ALU.
REQ-010 alu_a, alu_b  output  DW  operands driven to the shared ALU.
REQ-011 alu_out  input  DW  ALU result, combinational from alu_op/alu_a/alu_b.
REQ-012 alu_sign, alu_zero, alu_parity, alu_ovf  input  1 each  ALU flags, combinational.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumer accept.
REQ-015 rsp_id  output  $clog2(NREQ)  requester index owning the response.
REQ-016 rsp_data  output  DW  captured result.
REQ-017 rsp_flags  output  4  captured {sign, zero, parity, overflow}.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-019 IDLE: when any req_valid is high, the block SHALL grant exactly one requester by round-robin, assert its req_ready in that same cycle, register its op/a/b and index, and move to ISSUE; otherwise it SHALL stay in IDLE with req_ready = 0.
REQ-020 Round-robin: search SHALL start at pointer ptr; after a grant to i, ptr SHALL become (i+1) mod NREQ; ptr SHALL be unchanged when nothing is granted.
REQ-021 ISSUE: alu_op/alu_a/alu_b SHALL present the registered values for exactly one cycle; at the end of that cycle alu_out and flags SHALL be captured into rsp_data/rsp_flags; the next state SHALL be RESP.
REQ-022 Flag masking: captured sign SHALL be alu_sign for ADD/SUB and 0 otherwise; captured overflow SHALL be alu_ovf for ADD only and 0 otherwise; zero and parity SHALL pass unmasked; rsp_flags SHALL never contain X.
REQ-023 RESP: rsp_valid SHALL be 1; on rsp_valid & rsp_ready the FSM SHALL return to IDLE.
REQ-024 While rsp_valid = 1 and rsp_ready = 0, rsp_id/rsp_data/rsp_flags SHALL hold stable.
REQ-025 req_ready SHALL be 0 in ISSUE and RESP; no new grant SHALL occur before the return to IDLE; minimum issue interval is 3 cycles.
REQ-026 Outside ISSUE, alu_op/alu_a/alu_b SHALL hold their last registered values (no toggling).
REQ-027 Requesters SHALL hold req_valid and operands until req_ready; the block need not tolerate withdrawal.
REQ-028 Request-to-response latency SHALL be 2 cycles: grant in cycle N, rsp_valid high in cycle N+2.

Reset
REQ-029 On rst_n low, asynchronously: state = IDLE, ptr = 0, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_flags = 0, alu_op = 0, alu_a = 0, alu_b = 0.
REQ-030 Reset during ISSUE or RESP SHALL discard the in-flight operation with no response emitted.

Structure
REQ-031 Package alu_sched_pkg SHALL hold the opcode localparams, the FSM state enum, and a flag struct {sign, zero, parity, ovf}.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant and index), combinational.

Verification
REQ-033 Reset then req_valid[0], ADD 0x7FFF+0x0001 -> grant cycle N, rsp_valid at N+2, rsp_id 0, rsp_data 0x8000, flags {1,0,0,1}.
REQ-034 All four req_valid held high, rsp_ready = 1 -> grant order 0,1,2,3,0, grants spaced exactly 3 cycles.
REQ-035 XOR 0x00FF^0x00FF from requester 2 -> rsp_data 0x0000, flags {0,1,1,0}; sign/ovf 0 despite X from ALU.
REQ-036 SUB 0x0003-0x0005, rsp_ready low 5 cycles -> rsp_valid held, rsp_data 0xFFFE stable, flags {1,0,0,0}, no req_ready during stall.
REQ-037 rst_n asserted during RESP -> rsp_valid 0 immediately, ptr 0, next grant goes to lowest valid index.
REQ-038 Only req_valid[3] after grant to 3 -> ptr 0, requester 3 regranted when it alone is valid.
